spectrum_frame_buf: RTL and testbench

Parametrised ping-pong frame buffer for multi-channel spectrum magnitudes. FFT magnitude frames are written into a back bank while the display path reads a stable front bank, so a frame is never displayed half-written. Bank swaps occur only at a display frame boundary. The block runs in a single clock domain between the FFT magnitude stage and the spectrum renderer, and supersedes the fixed 8192×10 dual-port spectrum store.

---
 rtl/spectrum_frame_buf.sv | 163 ++++++++++++++++
 tb/tb_spectrum_frame_buf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_frame_buf.sv
// rtl/spectrum_frame_buf.sv - ping-pong frame buffer for multi-channel spectrum magnitudes
//
// Purpose:
//   Double-buffered bin store. The FFT magnitude stage fills the back bank
//   while the renderer reads the front bank. A completed back frame is held
//   pending until the next display frame boundary (rd_sync), where the banks
//   swap, so the renderer never sees a half-written frame.
//
// Ports:
//   clk, rst_n           single clock, asynchronous active-low reset
//   wr_en/wr_ch/wr_addr/wr_data
//                        one bin write into the back bank
//   wr_frame_done        pulse: back bank holds a complete frame
//   wr_ready             back bank accepts writes (no frame pending)
//   rd_sync              pulse: display frame boundary, swap point
//   rd_en/rd_ch/rd_addr  read request into the front bank (2-cycle latency)
//   rd_data/rd_valid     zero-extended bin and its strobe
//   disp_valid           front bank holds a complete frame (sticky)
//   frame_cnt            completed swaps, wrapping
//   ovf_cnt              frames rejected because one was already pending, saturating

module spectrum_frame_buf #(
  parameter  int DATA_W = 10,
  parameter  int OUT_W  = 11,
  parameter  int ADDR_W = 13,
  parameter  int DEPTH  = 8192,
  parameter  int NUM_CH = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  output logic              wr_ready,
  input  logic              rd_sync,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              disp_valid,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       ovf_cnt
);

  // Flat storage: bank-major, then channel, then bin. DEPTH need not be a
  // power of two, so the index is computed arithmetically.
  localparam int BANK_SZ = NUM_CH * DEPTH;
  localparam int MEM_SZ  = 2 * BANK_SZ;
  localparam int IDX_W   = (MEM_SZ > 1) ? $clog2(MEM_SZ) : 1;

  function automatic logic [IDX_W-1:0] mem_idx(
    input logic              bank,
    input logic [CH_W-1:0]   ch,
    input logic [ADDR_W-1:0] addr
  );
    int unsigned lin;
    lin = (bank ? 32'(BANK_SZ) : 32'd0) + 32'(ch) * 32'(DEPTH) + 32'(addr);
    return IDX_W'(lin);
  endfunction

  logic [DATA_W-1:0] mem [MEM_SZ];

  logic wbank;
  logic pending;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_accept;
  logic swap;

  logic             s1_valid;
  logic             s1_oob;
  logic [IDX_W-1:0] s1_idx;
  logic             s2_valid;
  logic             s2_oob;
  logic [DATA_W-1:0] ram_q;

  assign wr_in_range = (int'(wr_addr) < DEPTH) && (int'(wr_ch) < NUM_CH);
  assign rd_in_range = (int'(rd_addr) < DEPTH) && (int'(rd_ch) < NUM_CH);

  // A pending frame is frozen: nothing may land in the back bank until it
  // has been swapped to the front.
  assign wr_ready  = !pending;
  assign wr_accept = wr_en && !pending && wr_in_range;
  assign swap      = rd_sync && pending;

  // ---------------------------------------------------------------------
  // RAM write and read ports (contents intentionally not reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[mem_idx(wbank, wr_ch, wr_addr)] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    ram_q <= mem[s1_idx];
  end

  // ---------------------------------------------------------------------
  // Bank control
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank      <= 1'b0;
      pending    <= 1'b0;
      disp_valid <= 1'b0;
      frame_cnt  <= 16'd0;
      ovf_cnt    <= 16'd0;
    end else begin
      // Swap takes priority: a done pulse in the swap cycle still sees the
      // old pending=1 and is counted as overflow below.
      if (swap) begin
        wbank      <= !wbank;
        pending    <= 1'b0;
        disp_valid <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
      end else if (wr_frame_done && !pending) begin
        pending <= 1'b1;
      end

      if (wr_frame_done && pending && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline: capture (N), RAM output (N+1), output register (N+2)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_oob   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      // Front bank is sampled from the pre-edge wbank, so a read issued
      // together with a swapping rd_sync still targets the old front.
      s1_valid <= rd_en;
      s1_oob   <= !rd_in_range;
      // Out-of-range requests park the RAM address at 0 to keep the
      // access within the array; their data is zeroed at the output.
      s1_idx   <= rd_in_range ? mem_idx(!wbank, rd_ch, rd_addr) : '0;

      s2_valid <= s1_valid;
      s2_oob   <= s1_oob;

      rd_valid <= s2_valid;
      if (s2_valid) begin
        rd_data <= s2_oob ? '0 : OUT_W'(ram_q);
      end
    end
  end

endmodule

// File: tb/tb_spectrum_frame_buf.sv
// tb/tb_spectrum_frame_buf.sv - randomized self-checking bench for spectrum_frame_buf
module tb_spectrum_frame_buf;

  localparam int DATA_W = 10;
  localparam int OUT_W  = 11;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 1000;
  localparam int NUM_CH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [0:0]        wr_ch;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              wr_ready;
  logic              rd_sync;
  logic              rd_en;
  logic [0:0]        rd_ch;
  logic [ADDR_W-1:0] rd_addr;
  logic [OUT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              disp_valid;
  logic [15:0]       frame_cnt;
  logic [15:0]       ovf_cnt;

  spectrum_frame_buf #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .wr_ready(wr_ready),
    .rd_sync(rd_sync), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .disp_valid(disp_valid),
    .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: bank contents (-1 = unknown), bank/pending flags,
  // counters and a two-slot queue of expected read results.
  int mdl [2][NUM_CH][DEPTH];
  int m_wbank, m_pending, m_disp, m_frame, m_ovf;
  int p0_v, p0_d, p1_v, p1_d, out_v, out_d;

  task automatic model_reset();
    m_wbank = 0; m_pending = 0; m_disp = 0; m_frame = 0; m_ovf = 0;
    p0_v = 0; p0_d = 0; p1_v = 0; p1_d = 0; out_v = 0; out_d = 0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < NUM_CH; c++)
        for (int a = 0; a < DEPTH; a++)
          mdl[b][c][a] = -1;
  endtask

  task automatic model_edge();
    int front, d, do_swap;
    if (!rst_n) return;
    front = 1 - m_wbank;
    if (int'(rd_addr) >= DEPTH || int'(rd_ch) >= NUM_CH) d = 0;
    else d = mdl[front][int'(rd_ch)][int'(rd_addr)];
    out_v = p1_v; out_d = p1_d;
    p1_v = p0_v;  p1_d = p0_d;
    p0_v = int'(rd_en); p0_d = d;
    if (wr_en && m_pending == 0 && int'(wr_addr) < DEPTH && int'(wr_ch) < NUM_CH)
      mdl[m_wbank][int'(wr_ch)][int'(wr_addr)] = int'(wr_data);
    do_swap = (rd_sync && m_pending == 1) ? 1 : 0;
    if (wr_frame_done && m_pending == 1 && m_ovf < 65535) m_ovf++;
    if (do_swap == 1) begin
      m_wbank = 1 - m_wbank;
      m_pending = 0;
      m_disp = 1;
      m_frame = (m_frame + 1) % 65536;
    end else if (wr_frame_done && m_pending == 0) begin
      m_pending = 1;
    end
  endtask

  task automatic check_outputs();
    check("wr_ready",   int'(wr_ready),   1 - m_pending);
    check("disp_valid", int'(disp_valid), m_disp);
    check("frame_cnt",  int'(frame_cnt),  m_frame);
    check("ovf_cnt",    int'(ovf_cnt),    m_ovf);
    check("rd_valid",   int'(rd_valid),   out_v);
    if (out_v == 1 && out_d >= 0) check("rd_data", int'(rd_data), out_d);
  endtask

  task automatic clear_inputs();
    wr_en = 0; wr_ch = 0; wr_addr = 0; wr_data = 0; wr_frame_done = 0;
    rd_sync = 0; rd_en = 0; rd_ch = 0; rd_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    clear_inputs();
  endtask

  task automatic do_write(input int ch, input int addr, input int data);
    wr_en = 1; wr_ch = 1'(ch); wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
    tick();
  endtask

  task automatic issue_read(input int ch, input int addr);
    rd_en = 1; rd_ch = 1'(ch); rd_addr = ADDR_W'(addr);
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)      return ADDR_W'($urandom_range(0, 15));
    else if (r < 9) return ADDR_W'($urandom_range(DEPTH - 5, DEPTH + 5));
    else            return ADDR_W'($urandom_range(0, 8191));
  endfunction

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en         = 1'($urandom_range(0, 1));
      wr_ch         = 1'($urandom_range(0, 1));
      wr_addr       = pick_addr();
      wr_data       = DATA_W'($urandom_range(0, 1023));
      rd_en         = 1'($urandom_range(0, 1));
      rd_ch         = 1'($urandom_range(0, 1));
      rd_addr       = pick_addr();
      rd_sync       = ($urandom_range(0, 15) == 0);
      wr_frame_done = ($urandom_range(0, 19) == 0);
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 0;
    #1;
    check("reset rd_data", int'(rd_data), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    tick();
    tick();
    rst_n = 1;
    tick();

    // First frame: ch0 bins 0..7 = 100..107, complete, swap, read bin 3.
    for (int i = 0; i < 8; i++) do_write(0, i, 100 + i);
    wr_frame_done = 1; tick();
    rd_sync = 1; tick();
    issue_read(0, 3); tick();
    tick();
    tick();
    check("first read data", int'(rd_data), 103);
    check("first read disp", int'(disp_valid), 1);
    check("first read frame", int'(frame_cnt), 1);

    // Writes while a frame is pending are dropped.
    do_write(0, 3, 333);
    wr_frame_done = 1; tick();
    do_write(0, 3, 555);
    rd_sync = 1; tick();
    issue_read(0, 3); tick();
    tick();
    tick();
    check("discarded write", int'(rd_data), 333);

    // Overflow counting and saturation.
    wr_frame_done = 1; tick();
    for (int i = 0; i < 3; i++) begin
      wr_frame_done = 1; tick();
    end
    check("ovf after 3", int'(ovf_cnt), 3);
    check("pending held", int'(wr_ready), 0);
    force dut.ovf_cnt = 16'hFFFF;
    #1;
    release dut.ovf_cnt;
    m_ovf = 65535;
    wr_frame_done = 1; tick();
    check("ovf saturate", int'(ovf_cnt), 65535);

    // Same-cycle sync+done with nothing pending: no swap yet.
    rd_sync = 1; tick();
    check("frame after swap", int'(frame_cnt), 3);
    rd_sync = 1; wr_frame_done = 1; tick();
    check("no swap same cycle", int'(frame_cnt), 3);
    rd_sync = 1; tick();
    check("deferred swap", int'(frame_cnt), 4);

    // Back-to-back reads across channels and the DEPTH boundary.
    do_write(0, 10, 77);
    do_write(1, 10, 1023);
    wr_frame_done = 1; tick();
    rd_sync = 1; tick();
    issue_read(0, 10); tick();
    issue_read(1, 10); tick();
    issue_read(1, DEPTH); tick();
    check("b2b ch0", int'(rd_data), 77);
    tick();
    check("b2b ch1", int'(rd_data), 1023);
    check("b2b ch1 valid", int'(rd_valid), 1);
    tick();
    check("b2b oob", int'(rd_data), 0);
    check("b2b oob valid", int'(rd_valid), 1);

    random_cycles(3000);

    // Asynchronous reset in the middle of a read burst.
    for (int i = 0; i < 3; i++) begin
      issue_read($urandom_range(0, 1), $urandom_range(0, 15));
      tick();
    end
    issue_read(0, 1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async rd_valid", int'(rd_valid), 0);
    check("async frame_cnt", int'(frame_cnt), 0);
    check("async ovf_cnt", int'(ovf_cnt), 0);
    tick();
    rst_n = 1;
    tick();
    check("post reset wr_ready", int'(wr_ready), 1);
    check("post reset disp", int'(disp_valid), 0);

    random_cycles(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
